// File: rtl/reservation_station.sv
// Collapsing-queue issue buffer: holds renamed ops until both sources are ready,
// then issues the oldest ready entry. Slot 0 is always the oldest entry.
module reservation_station #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 6,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_opcode,
  input  logic [PW-1:0] in_ps1,
  input  logic [PW-1:0] in_ps2,
  input  logic [PW-1:0] in_pd,
  input  logic [31:0]   in_instr,
  input  logic          in_rdy1,
  input  logic          in_rdy2,
  input  logic          cdb_valid,
  input  logic [PW-1:0] cdb_tag,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [6:0]    iss_opcode,
  output logic [PW-1:0] iss_ps1,
  output logic [PW-1:0] iss_ps2,
  output logic [PW-1:0] iss_pd,
  output logic [31:0]   iss_instr,
  output logic [CW-1:0] count
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]    opcode;
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
    logic [PW-1:0] pd;
    logic [31:0]   instr;
  } payload_t;

  logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
  logic [DEPTH-1:0] valid_d, rdy1_d, rdy2_d;
  logic [DEPTH-1:0] wk1, wk2, qual;
  payload_t         pl_q [DEPTH];
  payload_t         pl_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    wr_idx;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic             iss_fire, disp_fire;
  logic             new_rdy1, new_rdy2;
  payload_t         new_pl, sel_pl;

  // Current-cycle CDB wakeup applied to every stored source tag
  always_comb begin
    wk1 = '0;
    wk2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = rdy1_q[i] | (cdb_valid & (pl_q[i].ps1 == cdb_tag));
      wk2[i] = rdy2_q[i] | (cdb_valid & (pl_q[i].ps2 == cdb_tag));
    end
    qual = valid_q & rdy1_q & rdy2_q;
  end

  // Oldest-ready select from registered state only
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (qual[i]) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign sel_pl     = sel_any ? pl_q[sel_idx] : '0;
  assign iss_valid  = sel_any;
  assign iss_opcode = sel_pl.opcode;
  assign iss_ps1    = sel_pl.ps1;
  assign iss_ps2    = sel_pl.ps2;
  assign iss_pd     = sel_pl.pd;
  assign iss_instr  = sel_pl.instr;
  assign in_ready   = (count_q < CW'(DEPTH));
  assign count      = count_q;

  assign iss_fire  = sel_any & iss_ready;
  assign disp_fire = in_valid & in_ready & ~flush;
  assign wr_idx    = count_q - CW'(iss_fire);

  // Same-cycle bypass from the CDB; tag 0 is hardwired ready
  assign new_rdy1 = in_rdy1 | (cdb_valid & (cdb_tag == in_ps1)) | (in_ps1 == '0);
  assign new_rdy2 = in_rdy2 | (cdb_valid & (cdb_tag == in_ps2)) | (in_ps2 == '0);
  assign new_pl   = '{opcode: in_opcode, ps1: in_ps1, ps2: in_ps2, pd: in_pd, instr: in_instr};

  // Next-state: wakeup, collapse above the issued slot, then append dispatch
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = wk1;
    rdy2_d  = wk2;
    for (int i = 0; i < DEPTH; i++) pl_d[i] = pl_q[i];

    if (iss_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          valid_d[i] = valid_q[i+1];
          rdy1_d[i]  = wk1[i+1];
          rdy2_d[i]  = wk2[i+1];
          pl_d[i]    = pl_q[i+1];
        end
      end
      valid_d[DEPTH-1] = 1'b0;
    end

    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          valid_d[i] = 1'b1;
          rdy1_d[i]  = new_rdy1;
          rdy2_d[i]  = new_rdy2;
          pl_d[i]    = new_pl;
        end
      end
    end

    if (flush) valid_d = '0;

    if (flush) count_d = '0;
    else       count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) pl_q[i] <= pl_d[i];
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch/issue ordering, wakeup, bypass,
// full/collapse behaviour, issue stall, flush and reset.
module tb_reservation_station;

  localparam int unsigned PW = 6;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [6:0]    in_opcode;
  logic [PW-1:0] in_ps1, in_ps2, in_pd;
  logic [31:0]   in_instr;
  logic          in_rdy1, in_rdy2, cdb_valid;
  logic [PW-1:0] cdb_tag;
  logic          iss_valid, iss_ready;
  logic [6:0]    iss_opcode;
  logic [PW-1:0] iss_ps1, iss_ps2, iss_pd;
  logic [31:0]   iss_instr;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  reservation_station #(.DEPTH(8), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ps1(in_ps1), .in_ps2(in_ps2), .in_pd(in_pd),
    .in_instr(in_instr), .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
    .iss_instr(iss_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic v, input int ps1, input int ps2, input int pd,
                      input logic r1, input logic r2);
    in_valid  = v;
    in_opcode = 7'(pd + 3);
    in_ps1    = PW'(ps1);
    in_ps2    = PW'(ps2);
    in_pd     = PW'(pd);
    in_instr  = 32'(pd * 16 + 1);
    in_rdy1   = r1;
    in_rdy2   = r2;
  endtask

  task automatic cdb(input logic v, input int tag);
    cdb_valid = v;
    cdb_tag   = PW'(tag);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    cdb(1'b0, 0);
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_pd", 32'(iss_pd), 0);
    reset = 1'b0;

    // 1: single ready dispatch issues the next cycle
    iss_ready = 1'b1;
    disp(1'b1, 3, 4, 10, 1'b1, 1'b1);
    step();
    chk("t1_iss_valid", 32'(iss_valid), 1);
    chk("t1_iss_pd", 32'(iss_pd), 10);
    chk("t1_iss_instr", iss_instr, 32'(10 * 16 + 1));
    chk("t1_count", 32'(count), 1);
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    step();
    chk("t1_count_after", 32'(count), 0);
    chk("t1_empty", 32'(iss_valid), 0);

    // 2: younger ready entry bypasses an older waiting one; CDB wakes the older
    disp(1'b1, 5, 0, 20, 1'b0, 1'b0);
    step();
    chk("t2_a_waits", 32'(iss_valid), 0);
    disp(1'b1, 7, 8, 21, 1'b1, 1'b1);
    step();
    chk("t2_b_first", 32'(iss_pd), 21);
    chk("t2_count2", 32'(count), 2);
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    cdb(1'b1, 5);
    step();
    cdb(1'b0, 0);
    chk("t2_a_valid", 32'(iss_valid), 1);
    chk("t2_a_pd", 32'(iss_pd), 20);
    chk("t2_count1", 32'(count), 1);
    step();
    chk("t2_drained", 32'(count), 0);

    // 4: dispatch-cycle CDB bypass, ps2 is tag 0
    disp(1'b1, 9, 0, 30, 1'b0, 1'b0);
    cdb(1'b1, 9);
    step();
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    cdb(1'b0, 0);
    chk("t4_bypass_valid", 32'(iss_valid), 1);
    chk("t4_bypass_pd", 32'(iss_pd), 30);
    step();
    chk("t4_drained", 32'(count), 0);

    // 3: fill with waiting entries, wake slot 3, collapse
    for (int i = 0; i < 8; i++) begin
      disp(1'b1, 40 + i, 0, i + 1, 1'b0, 1'b0);
      step();
    end
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("t3_full_count", 32'(count), 8);
    chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_none_ready", 32'(iss_valid), 0);
    cdb(1'b1, 43);
    step();
    cdb(1'b0, 0);
    chk("t3_slot3_pd", 32'(iss_pd), 4);
    disp(1'b1, 61, 0, 60, 1'b1, 1'b1);
    step();
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("t3_count7", 32'(count), 7);
    chk("t3_ready_again", 32'(in_ready), 1);
    chk("t3_no_stray", 32'(iss_valid), 0);
    iss_ready = 1'b0;
    cdb(1'b1, 47);
    step();
    chk("t3_shifted_top", 32'(iss_pd), 8);
    cdb(1'b1, 40);
    step();
    cdb(1'b0, 0);
    chk("t3_older_wins", 32'(iss_pd), 1);

    // 5: stall holds the oldest ready selection
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_hold_pd", 32'(iss_pd), 1);
      chk("t5_hold_ps1", 32'(iss_ps1), 40);
      chk("t5_hold_count", 32'(count), 7);
    end

    // 6: flush with concurrent dispatch
    flush = 1'b1;
    disp(1'b1, 0, 0, 55, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("t6_flush_count", 32'(count), 0);
    chk("t6_flush_iss", 32'(iss_valid), 0);
    for (int i = 0; i < 5; i++) begin
      disp(1'b1, 0, 0, 33 + i, 1'b1, 1'b1);
      step();
    end
    chk("t6_five", 32'(count), 5);
    chk("t6_five_oldest", 32'(iss_pd), 33);
    flush = 1'b1;
    disp(1'b1, 0, 0, 50, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("t6_flush2_count", 32'(count), 0);
    chk("t6_flush2_iss", 32'(iss_valid), 0);

    // 6b: reset mid-fill
    for (int i = 0; i < 3; i++) begin
      disp(1'b1, 0, 0, 12 + i, 1'b1, 1'b1);
      step();
    end
    chk("t6_fill3", 32'(count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    disp(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_iss", 32'(iss_valid), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
